instr_encoder_loader: RTL

- Encodes structured instruction descriptors into 32-bit ARM machine words and writes them sequentially into instruction memory.
- It is the encode direction of the control path's main instruction decoder. Its instruction classes and field placement are exactly those the decoder consumes: DP reg/imm, MUL/long MUL, LDR/STR with index modes, B/BL, BX.
- Sits between the testbench/boot-loader descriptor source and the imem write port. It lets programs be built from fields instead of hand-assembled hex.

---
 rtl/arm_pkg.sv | 25 ++
 rtl/instr_encoder_loader_if.sv | 32 +++
 rtl/instr_field_encoder.sv | 51 +++++
 rtl/instr_encoder_loader.sv | 131 +++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared encoding constants and types for the instruction encoder/loader.
package arm_pkg;

  typedef enum logic [2:0] {
    DT_DP_REG = 3'd0,
    DT_DP_IMM = 3'd1,
    DT_MUL    = 3'd2,
    DT_MEM    = 3'd3,
    DT_B      = 3'd4,
    DT_BX     = 3'd5
  } desc_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [1:0]  OP_DP      = 2'b00;
  localparam logic [1:0]  OP_MEM     = 2'b01;
  localparam logic [1:0]  OP_BR      = 2'b10;
  localparam logic [23:0] BX_CONST   = 24'h12FFF1;
  localparam logic [3:0]  MUL_MARKER = 4'b1001;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Descriptor channel between the program source and the loader.
interface instr_encoder_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              desc_valid;
  logic              desc_ready;
  logic [2:0]        desc_type;
  logic [3:0]        cond;
  logic [3:0]        cmd;
  logic              s;
  logic [3:0]        rd;
  logic [3:0]        rn;
  logic [3:0]        rm;
  logic [3:0]        ra;
  logic [11:0]       imm12;
  logic [4:0]        mem_flags;
  logic              mem_reg;
  logic              link;
  logic [ADDR_W-1:0] target;

  modport master (
    output desc_valid, desc_type, cond, cmd, s, rd, rn, rm, ra,
           imm12, mem_flags, mem_reg, link, target,
    input  desc_ready
  );

  modport slave (
    input  desc_valid, desc_type, cond, cmd, s, rd, rn, rm, ra,
           imm12, mem_flags, mem_reg, link, target,
    output desc_ready
  );
endinterface

// File: rtl/instr_field_encoder.sv
// Combinational descriptor-to-ARM-word encoder; pc is the word address being written.
module instr_field_encoder
  import arm_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic [2:0]        i_desc_type,
  input  logic [3:0]        i_cond,
  input  logic [3:0]        i_cmd,
  input  logic              i_s,
  input  logic [3:0]        i_rd,
  input  logic [3:0]        i_rn,
  input  logic [3:0]        i_rm,
  input  logic [3:0]        i_ra,
  input  logic [11:0]       i_imm12,
  input  logic [4:0]        i_mem_flags,
  input  logic              i_mem_reg,
  input  logic              i_link,
  input  logic [ADDR_W-1:0] i_target,
  input  logic [ADDR_W:0]   i_pc,
  output logic [31:0]       o_word_c,
  output logic              o_type_ok_c,
  output logic              o_range_err_c
);

  // Branch offset relative to PC+8, i.e. two words past the write address.
  logic [31:0] w_off;
  assign w_off = 32'(i_target) - 32'(i_pc) - 32'd2;

  // Field placement per instruction class.
  always_comb begin
    o_word_c      = '0;
    o_type_ok_c   = 1'b1;
    o_range_err_c = 1'b0;
    case (i_desc_type)
      DT_DP_REG: o_word_c = {i_cond, OP_DP, 1'b0, i_cmd, i_s, i_rn, i_rd, 8'h00, i_rm};
      DT_DP_IMM: o_word_c = {i_cond, OP_DP, 1'b1, i_cmd, i_s, i_rn, i_rd, i_imm12};
      DT_MUL:    o_word_c = {i_cond, 4'b0000, i_cmd[2:0], i_s, i_rd, i_ra, i_rm,
                             MUL_MARKER, i_rn};
      DT_MEM:    o_word_c = {i_cond, OP_MEM, i_mem_reg, i_mem_flags, i_rn, i_rd,
                             (i_mem_reg ? {8'h00, i_rm} : i_imm12)};
      DT_B: begin
        o_word_c      = {i_cond, OP_BR, 1'b1, i_link, w_off[23:0]};
        o_range_err_c = (w_off[31:23] != 9'h000) && (w_off[31:23] != 9'h1FF);
      end
      DT_BX:     o_word_c = {i_cond, BX_CONST, i_rm};
      default:   o_type_ok_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts instruction descriptors, encodes them and writes them sequentially into imem.
module instr_encoder_loader
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  instr_encoder_loader_if.slave desc,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [31:0]         imem_wdata,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                err
);

  localparam int unsigned      CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  state_t              r_state;
  logic                r_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [CNT_W-1:0]    r_count;
  logic                r_full;
  logic                r_err;

  logic [31:0]         w_word;
  logic                w_type_ok;
  logic                w_range_err;
  logic                w_accept;
  logic [CNT_W-1:0]    w_count_inc;

  assign w_accept    = desc.desc_valid && r_ready && (r_state == ST_IDLE);
  assign w_count_inc = r_count + CNT_W'(1);

  instr_field_encoder #(.ADDR_W(ADDR_W)) u_enc (
    .i_desc_type   (desc.desc_type),
    .i_cond        (desc.cond),
    .i_cmd         (desc.cmd),
    .i_s           (desc.s),
    .i_rd          (desc.rd),
    .i_rn          (desc.rn),
    .i_rm          (desc.rm),
    .i_ra          (desc.ra),
    .i_imm12       (desc.imm12),
    .i_mem_flags   (desc.mem_flags),
    .i_mem_reg     (desc.mem_reg),
    .i_link        (desc.link),
    .i_target      (desc.target),
    .i_pc          (r_count),
    .o_word_c      (w_word),
    .o_type_ok_c   (w_type_ok),
    .o_range_err_c (w_range_err)
  );

  // Loader FSM with counter and registered imem port; clear outranks an accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_we    <= 1'b0;
          r_ready <= 1'b1;
          if (w_accept) begin
            if (w_type_ok) begin
              r_wdata <= w_word;
              r_addr  <= r_count[ADDR_W-1:0];
              r_we    <= 1'b1;
              r_ready <= 1'b0;
              r_err   <= r_err | w_range_err;
              r_state <= ST_WRITE;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          r_we    <= 1'b0;
          r_count <= w_count_inc;
          if (w_count_inc == DEPTH_CNT) begin
            r_state <= ST_FULL;
            r_full  <= 1'b1;
            r_ready <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        ST_FULL: begin
          r_we    <= 1'b0;
          r_ready <= 1'b0;
          r_full  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_we    <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign desc.desc_ready = r_ready;
  assign imem_we         = r_we;
  assign imem_addr       = r_addr;
  assign imem_wdata      = r_wdata;
  assign count           = r_count;
  assign full            = r_full;
  assign err             = r_err;

endmodule
